// File: rtl/cpu_bp_pkg.sv
// Shared helpers for the branch target predictor: counter constants and
// PC field extraction. PCs are widened to 128 bits so one helper serves any DATA_W.
package cpu_bp_pkg;

   function automatic int CNT_WEAK_TAKEN(input int cnt_w);
      return 1 << (cnt_w - 1);
   endfunction

   function automatic int CNT_MAX(input int cnt_w);
      return (1 << cnt_w) - 1;
   endfunction

   function automatic logic [31:0] pc_index(input logic [127:0] pc, input int idx_w);
      logic [127:0] mask;
      mask = (128'd1 << idx_w) - 128'd1;
      return 32'((pc >> 2) & mask);
   endfunction

   function automatic logic [63:0] pc_tag(input logic [127:0] pc, input int idx_w,
                                          input int tag_w);
      logic [127:0] mask;
      mask = (128'd1 << tag_w) - 128'd1;
      return 64'((pc >> (idx_w + 2)) & mask);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Next-value logic for an N-bit saturating direction counter.
// load (allocation) wins over inc/dec and sets the weakly-taken value.
module sat_counter
   import cpu_bp_pkg::*;
#(
   parameter int CNT_W = 2
) (
   input  logic [CNT_W-1:0] i_cur,
   input  logic             i_inc,
   input  logic             i_dec,
   input  logic             i_load,
   output logic [CNT_W-1:0] o_nxt
);

   localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(CNT_MAX(CNT_W));
   localparam logic [CNT_W-1:0] C_WEAK = CNT_W'(CNT_WEAK_TAKEN(CNT_W));

   always_comb begin
      o_nxt = i_cur;
      if (i_load) begin
         o_nxt = C_WEAK;
      end else if (i_inc && (i_cur != C_MAX)) begin
         o_nxt = i_cur + CNT_W'(1);
      end else if (i_dec && (i_cur != '0)) begin
         o_nxt = i_cur - CNT_W'(1);
      end
   end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped tagged BTB with per-entry saturating direction counters.
// Lookup is combinational from if_pc; updates from ID-stage resolution land on the clock edge.
module branch_target_predictor
   import cpu_bp_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int IDX_W  = 4,
   parameter int TAG_W  = 8,
   parameter int CNT_W  = 2,
   parameter int STAT_W = 32
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              enable,
   input  logic              clear,
   input  logic [DATA_W-1:0] if_pc,
   output logic              pred_taken,
   output logic [DATA_W-1:0] pred_target,
   input  logic              upd_valid,
   input  logic [DATA_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [DATA_W-1:0] upd_target,
   input  logic              upd_mispredict,
   output logic [STAT_W-1:0] stat_mispredict
);

   localparam int DEPTH = 1 << IDX_W;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [CNT_W-1:0]  cnt;
      logic [DATA_W-1:0] target;
   } entry_t;

   entry_t            r_tbl [DEPTH];
   logic [STAT_W-1:0] r_stat;

   logic [IDX_W-1:0] w_rd_idx;
   logic [TAG_W-1:0] w_rd_tag;
   logic             w_rd_hit;
   logic [IDX_W-1:0] w_up_idx;
   logic [TAG_W-1:0] w_up_tag;
   logic             w_up_hit;
   logic [CNT_W-1:0] w_cnt_nxt;

   assign w_rd_idx = IDX_W'(pc_index(128'(if_pc), IDX_W));
   assign w_rd_tag = TAG_W'(pc_tag(128'(if_pc), IDX_W, TAG_W));
   assign w_up_idx = IDX_W'(pc_index(128'(upd_pc), IDX_W));
   assign w_up_tag = TAG_W'(pc_tag(128'(upd_pc), IDX_W, TAG_W));

   // Reads see the registered table only, so a same-cycle update is not bypassed.
   assign w_rd_hit    = r_tbl[w_rd_idx].valid && (r_tbl[w_rd_idx].tag == w_rd_tag);
   assign pred_taken  = w_rd_hit && r_tbl[w_rd_idx].cnt[CNT_W-1];
   assign pred_target = pred_taken ? r_tbl[w_rd_idx].target : '0;

   assign w_up_hit = r_tbl[w_up_idx].valid && (r_tbl[w_up_idx].tag == w_up_tag);

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_sat_counter (
      .i_cur (r_tbl[w_up_idx].cnt),
      .i_inc (w_up_hit && upd_taken),
      .i_dec (w_up_hit && !upd_taken),
      .i_load(!w_up_hit && upd_taken),
      .o_nxt (w_cnt_nxt)
   );

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_tbl[i] <= '0;
         end
      end else if (enable) begin
         if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
               r_tbl[i].valid <= 1'b0;
            end
         end else if (upd_valid) begin
            if (w_up_hit) begin
               r_tbl[w_up_idx].cnt <= w_cnt_nxt;
               if (upd_taken) begin
                  r_tbl[w_up_idx].target <= upd_target;
               end
            end else if (upd_taken) begin
               r_tbl[w_up_idx] <= '{valid: 1'b1, tag: w_up_tag, cnt: w_cnt_nxt,
                                    target: upd_target};
            end
         end
      end
   end

   // Statistics ignore clear; they only freeze when the pipeline stalls.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_stat <= '0;
      end else if (enable && upd_valid && upd_mispredict && (r_stat != '1)) begin
         r_stat <= r_stat + STAT_W'(1);
      end
   end

   assign stat_mispredict = r_stat;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Randomised + directed bench for branch_target_predictor against an array-based
// reference model; lookups are queued by the driver and checked by a separate monitor.
module tb_branch_target_predictor;

   localparam int DATA_W = 64;
   localparam int IDX_W  = 4;
   localparam int TAG_W  = 8;
   localparam int CNT_W  = 2;
   localparam int STAT_W = 4;
   localparam int DEPTH  = 1 << IDX_W;
   localparam int EXP_W  = 1 + DATA_W + STAT_W;

   logic              clk;
   logic              arst_n;
   logic              enable;
   logic              clear;
   logic [DATA_W-1:0] if_pc;
   logic              pred_taken;
   logic [DATA_W-1:0] pred_target;
   logic              upd_valid;
   logic [DATA_W-1:0] upd_pc;
   logic              upd_taken;
   logic [DATA_W-1:0] upd_target;
   logic              upd_mispredict;
   logic [STAT_W-1:0] stat_mispredict;

   branch_target_predictor #(
      .DATA_W(DATA_W), .IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(CNT_W), .STAT_W(STAT_W)
   ) dut (
      .clk            (clk),
      .arst_n         (arst_n),
      .enable         (enable),
      .clear          (clear),
      .if_pc          (if_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_taken      (upd_taken),
      .upd_target     (upd_target),
      .upd_mispredict (upd_mispredict),
      .stat_mispredict(stat_mispredict)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: one record per table slot, plain integers
   bit          m_valid [DEPTH];
   longint      m_tag   [DEPTH];
   int          m_cnt   [DEPTH];
   logic [63:0] m_tgt   [DEPTH];
   int          m_stat;

   logic [EXP_W-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   function automatic int idx_of(input logic [63:0] pc);
      return int'((pc >> 2) % 64'(DEPTH));
   endfunction

   function automatic longint tag_of(input logic [63:0] pc);
      return longint'((pc >> (IDX_W + 2)) % (64'd1 << TAG_W));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_valid[i] = 0;
         m_tag[i]   = 0;
         m_cnt[i]   = 0;
         m_tgt[i]   = '0;
      end
      m_stat = 0;
   endtask

   function automatic logic [EXP_W-1:0] model_lookup(input logic [63:0] pc);
      int          i;
      bit          taken;
      logic [63:0] tgt;
      i     = idx_of(pc);
      // predicted taken when the counter sits in the upper half of its range
      taken = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_cnt[i] >= (1 << (CNT_W - 1)));
      tgt   = taken ? m_tgt[i] : 64'd0;
      return {taken, tgt, STAT_W'(m_stat)};
   endfunction

   task automatic model_update(input bit en, input bit clr, input bit uv,
                               input logic [63:0] upc, input bit ut,
                               input logic [63:0] utgt, input bit um);
      int i;
      if (!en) return;
      if (uv && um && m_stat < (1 << STAT_W) - 1) m_stat++;
      if (clr) begin
         for (int k = 0; k < DEPTH; k++) m_valid[k] = 0;
         return;
      end
      if (!uv) return;
      i = idx_of(upc);
      if (m_valid[i] && m_tag[i] == tag_of(upc)) begin
         if (ut) begin
            if (m_cnt[i] < (1 << CNT_W) - 1) m_cnt[i]++;
            m_tgt[i] = utgt;
         end else if (m_cnt[i] > 0) begin
            m_cnt[i]--;
         end
      end else if (ut) begin
         m_valid[i] = 1;
         m_tag[i]   = tag_of(upc);
         m_cnt[i]   = 1 << (CNT_W - 1);
         m_tgt[i]   = utgt;
      end
   endtask

   // driver: one call = one cycle; expectation reflects state after the previous edge
   task automatic cyc(input logic [63:0] pc, input bit en, input bit clr, input bit uv,
                      input logic [63:0] upc, input bit ut, input logic [63:0] utgt,
                      input bit um);
      @(posedge clk);
      #1;
      arst_n         = 1'b1;
      if_pc          = pc;
      enable         = en;
      clear          = clr;
      upd_valid      = uv;
      upd_pc         = upc;
      upd_taken      = ut;
      upd_target     = utgt;
      upd_mispredict = um;
      exp_q.push_back(model_lookup(pc));
      model_update(en, clr, uv, upc, ut, utgt, um);
   endtask

   task automatic look(input logic [63:0] pc);
      cyc(pc, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
   endtask

   task automatic upd(input logic [63:0] pc, input bit ut, input logic [63:0] tgt,
                      input bit um);
      cyc(pc, 1'b1, 1'b0, 1'b1, pc, ut, tgt, um);
   endtask

   // asynchronous reset in the middle of traffic, with an update pending on the bus
   task automatic mid_reset(input logic [63:0] pc);
      @(posedge clk);
      #1;
      arst_n     = 1'b0;
      if_pc      = pc;
      enable     = 1'b1;
      upd_valid  = 1'b1;
      upd_pc     = pc;
      upd_taken  = 1'b1;
      upd_target = 64'h1234;
      upd_mispredict = 1'b1;
      model_reset();
      exp_q.push_back(model_lookup(pc));
   endtask

   function automatic logic [63:0] rand_pc();
      logic [63:0] p;
      p = ($urandom_range(0, 3) == 0) ? {32'($urandom), 32'd0} : 64'd0;
      p = p | (64'($urandom_range(0, 3)) << (IDX_W + 2))
            | (64'($urandom_range(0, DEPTH - 1)) << 2)
            | 64'($urandom_range(0, 3));
      return p;
   endfunction

   // scoreboard monitor: samples half a cycle after the driver
   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      logic [EXP_W-1:0] a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {pred_taken, pred_target, stat_mispredict};
         n_checks++;
         if (a !== e) begin
            n_errors++;
            $display("FAIL lookup pc=%h got taken=%0b tgt=%h stat=%0d expected taken=%0b tgt=%h stat=%0d",
                     if_pc, a[EXP_W-1], a[STAT_W +: DATA_W], a[STAT_W-1:0],
                     e[EXP_W-1], e[STAT_W +: DATA_W], e[STAT_W-1:0]);
         end
      end
   end

   initial begin
      logic [63:0] alias_pc;
      arst_n = 1'b0;
      enable = 1'b0;
      clear = 1'b0;
      if_pc = '0;
      upd_valid = 1'b0;
      upd_pc = '0;
      upd_taken = 1'b0;
      upd_target = '0;
      upd_mispredict = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);

      look(64'h100);
      upd(64'h100, 1'b1, 64'h200, 1'b1);
      look(64'h100);
      upd(64'h100, 1'b0, 64'h0, 1'b0);
      look(64'h100);
      upd(64'h100, 1'b1, 64'h999, 1'b0);
      look(64'h100);
      upd(64'h100, 1'b0, 64'h0, 1'b1);
      upd(64'h100, 1'b0, 64'h0, 1'b0);
      upd(64'h100, 1'b0, 64'h0, 1'b0);
      look(64'h100);
      upd(64'h100, 1'b1, 64'h200, 1'b0);
      upd(64'h100, 1'b1, 64'h200, 1'b0);
      look(64'h100);

      alias_pc = 64'h100 + (64'd1 << (IDX_W + 2 + TAG_W));
      upd(alias_pc, 1'b1, 64'h300, 1'b1);
      look(64'h100);
      look(alias_pc);

      cyc(64'h140, 1'b1, 1'b0, 1'b1, 64'h140, 1'b1, 64'h440, 1'b0);
      look(64'h140);
      cyc(64'h140, 1'b0, 1'b0, 1'b1, 64'h140, 1'b0, 64'h0, 1'b1);
      cyc(64'h140, 1'b0, 1'b0, 1'b1, 64'h140, 1'b0, 64'h0, 1'b1);
      look(64'h140);

      cyc(64'h180, 1'b1, 1'b1, 1'b1, 64'h180, 1'b1, 64'h580, 1'b1);
      look(64'h180);
      look(64'h140);
      look(alias_pc);

      for (int i = 0; i < 20; i++) begin
         cyc(64'h200 + 64'(i * 4), 1'b1, 1'b0, 1'b1, 64'h200 + 64'(i * 4),
             1'($urandom_range(0, 1)), 64'($urandom), 1'b1);
      end
      look(64'h200);

      for (int i = 0; i < 400; i++) begin
         logic [63:0] p;
         p = rand_pc();
         if (i == 200) begin
            mid_reset(p);
         end else begin
            cyc(rand_pc(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 3) != 0), p, 1'($urandom_range(0, 2) != 0),
                {32'($urandom), 32'($urandom)}, ($urandom_range(0, 7) == 0));
         end
      end

      repeat (3) @(posedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
